// File: rtl/cpu_types_pkg.sv
// Shared core types: machine word, RV32 base opcodes, and the fetch sequencer state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [6:0] {
        LTYPE  = 7'b0000011,
        ITYPE  = 7'b0010011,
        AUIPC  = 7'b0010111,
        STYPE  = 7'b0100011,
        RTYPE  = 7'b0110011,
        LUI    = 7'b0110111,
        BTYPE  = 7'b1100011,
        JALR   = 7'b1100111,
        JAL    = 7'b1101111,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH,
        REDIRECT,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/target_calc.sv
// Resolves control transfers in EX: decides whether fetch must redirect and where to.
module target_calc
    import cpu_types_pkg::*;
(
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        ex_br_taken,
    output logic        redir,
    output logic [31:0] target,
    output logic        misaligned
);

    opcode_t op;
    logic    is_jalr;
    word_t   raw;

    assign op      = opcode_t'(ex_opcode);
    assign is_jalr = (op == JALR);
    assign redir   = ex_valid & ((op == JAL) | is_jalr | ((op == BTYPE) & ex_br_taken));

    // Branch targets never reach the misaligned 2-byte case via bit 0; JALR clears it explicitly.
    assign raw        = is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    assign target     = {raw[31:2], 2'b00};
    assign misaligned = redir & raw[1];

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, sequences icache requests, applies EX redirects and stops fetch on HALT.
//  state    | meaning
//  FETCH    | requesting imemaddr=pc, accepting words into IF/ID
//  REDIRECT | redirect seen while a read was outstanding; wait for ihit, drop word, load pend_pc
//  HALTED   | fetch stopped until reset
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        halt,
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        ex_br_taken,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        flush,
    output logic        misaligned,
    output logic        halted
);

    fetch_state_t state;
    word_t        pc_q;
    word_t        pend_pc;
    logic         redir;
    word_t        target;

    target_calc u_target_calc (
        .ex_valid    (ex_valid),
        .ex_opcode   (ex_opcode),
        .ex_pc       (ex_pc),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_br_taken (ex_br_taken),
        .redir       (redir),
        .target      (target),
        .misaligned  (misaligned)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FETCH;
            pc_q    <= PC_INIT;
            pend_pc <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // The request address must stay put until the icache answers.
                    if (redir) begin
                        if (ihit) begin
                            pc_q <= target;
                        end else begin
                            pend_pc <= target;
                            state   <= REDIRECT;
                        end
                    end else if (ihit && !stall) begin
                        pc_q <= pc_q + PC_STEP;
                        if (halt) state <= HALTED;
                    end
                end
                REDIRECT: begin
                    if (redir) begin
                        if (ihit) begin
                            pc_q  <= target;
                            state <= FETCH;
                        end else begin
                            pend_pc <= target;
                        end
                    end else if (ihit) begin
                        pc_q  <= pend_pc;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign imemREN     = nRST & (state != HALTED);
    assign imemaddr    = pc_q;
    assign pc          = pc_q;
    assign npc         = pc_q + PC_STEP;
    assign instr_valid = nRST & (state == FETCH) & ihit & ~stall & ~redir;
    assign flush       = redir;
    assign halted      = (state == HALTED);

    // The pipeline flush should have removed any second control transfer behind the first.
    a_no_redir_in_redirect: assert property (@(posedge CLK) disable iff (!nRST)
        !((state == REDIRECT) && redir));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, sequential fetch, stalls, redirects, JALR alignment, halt.
module tb_fetch_sequencer;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        halt;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        ex_br_taken;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        flush;
    logic        misaligned;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    fetch_sequencer dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemREN(imemREN), .imemaddr(imemaddr),
        .stall(stall), .halt(halt), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_br_taken(ex_br_taken),
        .instr_valid(instr_valid), .pc(pc), .npc(npc), .flush(flush),
        .misaligned(misaligned), .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after posedge; checks happen 2 units later, well before the next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 0; stall = 0; halt = 0; ex_valid = 0; ex_opcode = RTYPE;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_br_taken = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 0;
        tick();
        tick();
        nRST = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        #2;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (imemREN !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b want 0", imemREN); end
        n_cmp++; if ({instr_valid, flush, misaligned, halted} !== 4'b0) begin n_err++;
            $display("FAIL reset_flags: got %b want 0000", {instr_valid, flush, misaligned, halted}); end
        tick();
        tick();
        nRST = 1;
        #2;
        n_cmp++; if (imemREN !== 1'b1) begin n_err++; $display("FAIL release_ren: got %b want 1", imemREN); end
        n_cmp++; if (imemaddr !== 32'h0) begin n_err++; $display("FAIL release_addr: got %h want %h", imemaddr, 32'h0); end
        tick();
    endtask

    task automatic test_sequential();
        do_reset();
        ihit = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++; if (imemaddr !== 32'(4 * i)) begin n_err++;
                $display("FAIL seq_addr[%0d]: got %h want %h", i, imemaddr, 32'(4 * i)); end
            n_cmp++; if (instr_valid !== 1'b1 || npc !== 32'(4 * i + 4)) begin n_err++;
                $display("FAIL seq_valid_npc[%0d]: got %b/%h want 1/%h", i, instr_valid, npc, 32'(4 * i + 4)); end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [6:0] hv;
        logic [6:0] sv;
        logic [6:0] vv;
        logic [31:0] ea;
        do_reset();
        // cycle:  0 1 2 3 4 5 6 ; word 0 stalled at cycle 2, accepted at 5; word 4 requested from 6
        hv = 7'b0100100;
        sv = 7'b0000100;
        vv = 7'b0100000;
        for (int i = 0; i < 7; i++) begin
            ihit = hv[i];
            stall = sv[i];
            ea = (i < 6) ? 32'h0 : 32'h4;
            #2;
            n_cmp++; if (imemaddr !== ea || instr_valid !== vv[i]) begin n_err++;
                $display("FAIL stall_cyc[%0d]: got %h/%b want %h/%b", i, imemaddr, instr_valid, ea, vv[i]); end
            tick();
        end
    endtask

    task automatic test_branch();
        do_reset();
        ihit = 1; ex_valid = 1; ex_opcode = BTYPE; ex_pc = 32'h40; ex_imm = 32'hFFFF_FFF8; ex_br_taken = 1;
        #2;
        n_cmp++; if (flush !== 1'b1 || instr_valid !== 1'b0) begin n_err++;
            $display("FAIL btype_taken: got flush %b valid %b want 1/0", flush, instr_valid); end
        tick();
        ex_valid = 0; ihit = 0;
        #2;
        n_cmp++; if (pc !== 32'h38) begin n_err++; $display("FAIL btype_pc: got %h want %h", pc, 32'h38); end
        tick();
        ex_valid = 1; ihit = 1; ex_br_taken = 0;
        #2;
        n_cmp++; if (flush !== 1'b0 || instr_valid !== 1'b1) begin n_err++;
            $display("FAIL btype_nt: got flush %b valid %b want 0/1", flush, instr_valid); end
        tick();
        ex_valid = 0; ihit = 0;
        #2;
        n_cmp++; if (pc !== 32'h3C) begin n_err++; $display("FAIL btype_nt_pc: got %h want %h", pc, 32'h3C); end
        tick();
    endtask

    task automatic test_redirect_pending();
        do_reset();
        ihit = 1;
        for (int i = 0; i < 8; i++) tick();
        ihit = 0; ex_valid = 1; ex_opcode = JAL; ex_pc = 32'h80; ex_imm = 32'h80;
        #2;
        n_cmp++; if (pc !== 32'h20 || flush !== 1'b1) begin n_err++;
            $display("FAIL jal_start: got pc %h flush %b want 20/1", pc, flush); end
        tick();
        ex_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_cmp++; if (imemaddr !== 32'h20 || imemREN !== 1'b1) begin n_err++;
                $display("FAIL jal_hold[%0d]: got %h/%b want 20/1", i, imemaddr, imemREN); end
            tick();
        end
        ihit = 1;
        #2;
        n_cmp++; if (instr_valid !== 1'b0 || imemaddr !== 32'h20) begin n_err++;
            $display("FAIL jal_discard: got valid %b addr %h want 0/20", instr_valid, imemaddr); end
        tick();
        ihit = 0;
        #2;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL jal_pc: got %h want %h", pc, 32'h100); end
        tick();
    endtask

    task automatic test_jalr();
        do_reset();
        ihit = 1; ex_valid = 1; ex_opcode = JALR; ex_rs1 = 32'h203; ex_imm = 32'h0;
        #2;
        n_cmp++; if (misaligned !== 1'b1 || flush !== 1'b1 || instr_valid !== 1'b0) begin n_err++;
            $display("FAIL jalr_mis: got mis %b flush %b valid %b want 1/1/0", misaligned, flush, instr_valid); end
        tick();
        ex_valid = 0; ihit = 0;
        #2;
        n_cmp++; if (pc !== 32'h200 || misaligned !== 1'b0) begin n_err++;
            $display("FAIL jalr_pc: got %h mis %b want 200/0", pc, misaligned); end
        tick();
        ihit = 1; ex_valid = 1; ex_rs1 = 32'hFFFF_FFF0; ex_imm = 32'h14;
        #2;
        n_cmp++; if (misaligned !== 1'b0 || flush !== 1'b1) begin n_err++;
            $display("FAIL jalr_wrap_flags: got mis %b flush %b want 0/1", misaligned, flush); end
        tick();
        ex_valid = 0; ihit = 0;
        #2;
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL jalr_wrap_pc: got %h want %h", pc, 32'h4); end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        ihit = 1;
        for (int i = 0; i < 4; i++) tick();
        halt = 1;
        #2;
        n_cmp++; if (pc !== 32'h10 || instr_valid !== 1'b1) begin n_err++;
            $display("FAIL halt_accept: got pc %h valid %b want 10/1", pc, instr_valid); end
        tick();
        halt = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++; if (halted !== 1'b1 || imemREN !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h14) begin n_err++;
                $display("FAIL halt_hold[%0d]: got h %b ren %b v %b pc %h want 1/0/0/14",
                         i, halted, imemREN, instr_valid, pc); end
            tick();
        end

        do_reset();
        ihit = 1; halt = 1; ex_valid = 1; ex_opcode = JAL; ex_pc = 32'h0; ex_imm = 32'h40;
        #2;
        n_cmp++; if (flush !== 1'b1 || instr_valid !== 1'b0) begin n_err++;
            $display("FAIL halt_redir: got flush %b valid %b want 1/0", flush, instr_valid); end
        tick();
        ex_valid = 0; stall = 1;
        #2;
        n_cmp++; if (halted !== 1'b0 || pc !== 32'h40 || imemREN !== 1'b1) begin n_err++;
            $display("FAIL halt_redir_pc: got h %b pc %h ren %b want 0/40/1", halted, pc, imemREN); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++;
            $display("FAIL halt_stall_valid: got %b want 0", instr_valid); end
        tick();
        stall = 0; halt = 0; ihit = 0;
        #2;
        n_cmp++; if (halted !== 1'b0 || pc !== 32'h40) begin n_err++;
            $display("FAIL halt_stall_pc: got h %b pc %h want 0/40", halted, pc); end

        ex_valid = 1; ex_opcode = JAL; ex_pc = 32'h40; ex_imm = 32'h40;
        tick();
        ex_valid = 0;
        #2;
        n_cmp++; if (imemaddr !== 32'h40 || imemREN !== 1'b1) begin n_err++;
            $display("FAIL rst_redir_hold: got %h/%b want 40/1", imemaddr, imemREN); end
        nRST = 0;
        #1;
        n_cmp++; if (pc !== 32'h0 || imemREN !== 1'b0) begin n_err++;
            $display("FAIL rst_redir_async: got pc %h ren %b want 0/0", pc, imemREN); end
        tick();
        nRST = 1; ihit = 1;
        #2;
        n_cmp++; if (instr_valid !== 1'b1 || imemaddr !== 32'h0) begin n_err++;
            $display("FAIL rst_redir_fetch: got v %b addr %h want 1/0", instr_valid, imemaddr); end
        tick();
        ihit = 0;
        #2;
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL rst_redir_pc: got %h want %h", pc, 32'h4); end
        tick();
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_redirect_pending();
        test_jalr();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
